// File: rtl/palette_loader_pkg.sv
// Shared types and defaults for the palette download loader.
// The colour word packs 5-bit channels as {B, G, R}.
package palette_loader_pkg;

  localparam int PAL_ENTRIES_DEF = 64;
  localparam int PAL_BYTES_DEF   = 192;
  localparam int RAM_AW          = 6;
  localparam int RAM_DEPTH       = 1 << RAM_AW;

  typedef logic [14:0] color_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BYTE_R = 2'd0,
    BYTE_G = 2'd1,
    BYTE_B = 2'd2
  } byte_sel_t;

  function automatic color_t pack_color(input logic [4:0] r, input logic [4:0] g,
                                        input logic [4:0] b);
    return {b, g, r};
  endfunction

endpackage

// File: rtl/palette_ram.sv
// 64x15 single-port palette RAM: synchronous write, registered read.
// The caller guarantees read and write are never requested together.
module palette_ram
  import palette_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [RAM_AW-1:0] addr,
  input  color_t            wdata,
  output color_t            rdata
);

  color_t mem [RAM_DEPTH];
  color_t rdata_q, rdata_d;

  // NOTE: the array itself is never reset, so it maps onto RAM macros; only the output register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/palette_loader.sv
// Palette download controller: assembles R/G/B byte triplets into 15-bit entries
// and writes them into a single-port RAM shared with the video lookup.
module palette_loader
  import palette_loader_pkg::*;
#(
  parameter int PAL_ENTRIES = PAL_ENTRIES_DEF,
  parameter int PAL_BYTES   = PAL_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        pix_ce_n,
  input  logic [5:0]  rd_addr,
  output logic [14:0] rd_data,
  output logic        pal_valid,
  output logic        busy
);

  localparam int IDX_W = $clog2(PAL_ENTRIES + 1);

  state_t            state_q, state_d;
  byte_sel_t         byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]  entry_idx_q, entry_idx_d;
  logic [4:0]        r_q, r_d, g_q, g_d;
  color_t            wdata_q, wdata_d;
  logic [RAM_AW-1:0] waddr_q, waddr_d;
  logic              pend_q, pend_d;
  logic              pal_valid_q, pal_valid_d;
  logic              load_en_q, load_en_d;

  logic              load_rise, start, byte_ok, commit, full;
  logic [RAM_AW-1:0] ram_addr;
  logic              unused_lsbs;

  assign load_en_d   = load_en;
  assign load_rise   = load_en && !load_en_q;
  assign start       = (state_q != LOAD) && load_rise;
  // A full palette is PAL_BYTES/3 complete triplets; anything beyond PAL_ENTRIES is dropped.
  assign full        = (entry_idx_q == IDX_W'(PAL_BYTES / 3));
  assign byte_ok     = (state_q == LOAD) && load_en && ioctl_wr && !pend_q &&
                       (entry_idx_q < IDX_W'(PAL_ENTRIES));
  assign commit      = pend_q && !pix_ce_n;
  assign unused_lsbs = ^ioctl_dout[2:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (load_rise) state_d = LOAD;
      LOAD:       if (!load_en && !pend_q) state_d = full ? DONE : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    entry_idx_d = entry_idx_q;
    r_d         = r_q;
    g_d         = g_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    pend_d      = pend_q;
    pal_valid_d = pal_valid_q;

    if (commit) pend_d = 1'b0;

    if (start) begin
      byte_cnt_d  = BYTE_R;
      entry_idx_d = '0;
      pal_valid_d = 1'b0;
    end else if (byte_ok) begin
      unique case (byte_cnt_q)
        BYTE_R: begin
          r_d        = ioctl_dout[7:3];
          byte_cnt_d = BYTE_G;
        end
        BYTE_G: begin
          g_d        = ioctl_dout[7:3];
          byte_cnt_d = BYTE_B;
        end
        BYTE_B: begin
          wdata_d     = pack_color(r_q, g_q, ioctl_dout[7:3]);
          waddr_d     = entry_idx_q[RAM_AW-1:0];
          entry_idx_d = entry_idx_q + 1'b1;
          pend_d      = 1'b1;
          byte_cnt_d  = BYTE_R;
        end
        default: byte_cnt_d = BYTE_R;
      endcase
    end

    if (state_q == LOAD && state_d != LOAD) pal_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q  <= BYTE_R;
      entry_idx_q <= '0;
      r_q         <= '0;
      g_q         <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      pend_q      <= 1'b0;
      pal_valid_q <= 1'b0;
      load_en_q   <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      entry_idx_q <= entry_idx_d;
      r_q         <= r_d;
      g_q         <= g_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      pend_q      <= pend_d;
      pal_valid_q <= pal_valid_d;
      load_en_q   <= load_en_d;
    end
  end

  // Video read owns the port whenever pix_ce_n is high; a pending write slips behind it.
  always_comb begin
    ioctl_wait = pend_q;
    busy       = (state_q == LOAD) || pend_q;
    pal_valid  = pal_valid_q;
    ram_addr   = pix_ce_n ? rd_addr : waddr_q;
  end

  palette_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .rd_en (pix_ce_n),
    .wr_en (commit),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (rd_data)
  );

endmodule
